// File: rtl/bp_be_issue_queue_pkg.sv
// Shared defaults and helpers for the replayable BE issue queue.
package bp_be_issue_queue_pkg;

  localparam int iq_els_default_lp   = 8;
  localparam int iq_width_default_lp = 128;

  function automatic int iq_ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_be_issue_queue_ptr.sv
// Wrap-bit circular pointer: loads val_i on set_i, else advances by inc_i.
module bp_be_issue_queue_ptr
  import bp_be_issue_queue_pkg::*;
#(
  parameter int els_p     = 8,
  parameter int max_inc_p = 1,
  localparam int ptr_width_lp = iq_ptr_width(els_p),
  localparam int inc_width_lp = $clog2(max_inc_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    set_i,
  input  logic [ptr_width_lp-1:0] val_i,
  input  logic [inc_width_lp-1:0] inc_i,
  output logic [ptr_width_lp-1:0] ptr_o
);

  // els_p is a power of two, so natural overflow wraps modulo 2*els_p
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      ptr_o <= '0;
    else if (set_i)
      ptr_o <= val_i;
    else
      ptr_o <= ptr_o + ptr_width_lp'(inc_i);
  end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Replayable issue buffer: speculative read pointer, commit pointer
// for retirement, roll back to commit and full clear.
module bp_be_issue_queue
  import bp_be_issue_queue_pkg::*;
#(
  parameter int els_p        = iq_els_default_lp,
  parameter int data_width_p = iq_width_default_lp,
  localparam int ptr_width_lp = iq_ptr_width(els_p),
  localparam int idx_width_lp = ptr_width_lp - 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  input  logic                    deq_i,
  input  logic                    roll_i,
  input  logic                    clr_i,
  output logic [ptr_width_lp-1:0] count_o,
  output logic                    full_o
);

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_n, cptr_inc;
  logic [ptr_width_lp-1:0] rptr_val;
  logic [data_width_p-1:0] mem_r [els_p];
  logic                    ready_r;
  logic                    enq;
  logic                    rptr_set;
  logic                    cptr_adv;
  logic                    rptr_adv;

  assign full_o = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
               && (wptr[idx_width_lp] != cptr[idx_width_lp]);
  assign count_o = wptr - cptr;
  assign v_o     = (rptr != wptr);
  assign ready_o = ready_r & ~full_o;
  assign data_o  = mem_r[rptr[idx_width_lp-1:0]];

  assign enq      = v_i & ready_o;
  assign wptr_n   = wptr + ptr_width_lp'(enq);
  assign cptr_inc = cptr + ptr_width_lp'(deq_i);

  // clr wins over roll; both reposition rptr, clr also drags cptr
  assign rptr_set = clr_i | roll_i;
  assign rptr_val = clr_i ? wptr_n : cptr_inc;
  assign rptr_adv = yumi_i & ~rptr_set;
  assign cptr_adv = deq_i & ~clr_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      ready_r <= 1'b0;
    else
      ready_r <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wptr[idx_width_lp-1:0]] <= data_i;
  end

  bp_be_issue_queue_ptr #(
    .els_p(els_p),
    .max_inc_p(1)
  ) u_wptr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .set_i  (1'b0),
    .val_i  ('0),
    .inc_i  (enq),
    .ptr_o  (wptr)
  );

  bp_be_issue_queue_ptr #(
    .els_p(els_p),
    .max_inc_p(1)
  ) u_rptr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .set_i  (rptr_set),
    .val_i  (rptr_val),
    .inc_i  (rptr_adv),
    .ptr_o  (rptr)
  );

  bp_be_issue_queue_ptr #(
    .els_p(els_p),
    .max_inc_p(1)
  ) u_cptr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .set_i  (clr_i),
    .val_i  (wptr_n),
    .inc_i  (cptr_adv),
    .ptr_o  (cptr)
  );

  a_yumi_valid: assert property (
    @(posedge clk_i) disable iff (!reset_i)
    yumi_i |-> v_o
  );

  a_deq_issued: assert property (
    @(posedge clk_i) disable iff (!reset_i)
    deq_i |-> (cptr != rptr)
  );

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Bench for bp_be_issue_queue: vector table, scoreboard and
// hand sequences on an 8-deep and a 4-deep instance.
module tb_bp_be_issue_queue;

  localparam int W = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i;

  logic [W-1:0] d8, do8;
  logic v8, yumi8, deq8, roll8, clr8;
  logic rdy8, vo8, full8;
  logic [3:0] cnt8;

  logic [W-1:0] d4, do4;
  logic v4, yumi4, deq4, roll4, clr4;
  logic rdy4, vo4, full4;
  logic [2:0] cnt4;

  bp_be_issue_queue #(.els_p(8), .data_width_p(W)) dut8 (
    .clk_i(clk), .reset_i(reset_i),
    .data_i(d8), .v_i(v8), .ready_o(rdy8),
    .data_o(do8), .v_o(vo8), .yumi_i(yumi8),
    .deq_i(deq8), .roll_i(roll8), .clr_i(clr8),
    .count_o(cnt8), .full_o(full8)
  );

  bp_be_issue_queue #(.els_p(4), .data_width_p(W)) dut4 (
    .clk_i(clk), .reset_i(reset_i),
    .data_i(d4), .v_i(v4), .ready_o(rdy4),
    .data_o(do4), .v_o(vo4), .yumi_i(yumi4),
    .deq_i(deq4), .roll_i(roll4), .clr_i(clr4),
    .count_o(cnt4), .full_o(full4)
  );

  typedef struct {
    int v; int d; int yumi; int deq; int roll; int clr;
    int ev; int ed; int ecnt;
  } vec_t;

  int nerr = 0;
  int nchk = 0;
  logic [W-1:0] sb[$];
  vec_t tbl[21];

  function automatic vec_t mk(input int v, d, y, q, r, c,
                              input int ev, ed, ecnt);
    vec_t t;
    t.v = v; t.d = d; t.yumi = y; t.deq = q; t.roll = r; t.clr = c;
    t.ev = ev; t.ed = ed; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    v8 = 0; yumi8 = 0; deq8 = 0; roll8 = 0; clr8 = 0; d8 = '0;
  endtask

  task automatic do_reset();
    idle8();
    reset_i = 0;
    step();
    step();
    reset_i = 1;
    step();
  endtask

  initial begin
    int ew, er, ec;
    logic fe, fy, fq;

    tbl[0]  = mk(1,  0, 0, 0, 0, 0, 1,  0, 1);
    tbl[1]  = mk(1,  1, 1, 0, 0, 0, 1,  1, 2);
    tbl[2]  = mk(1,  2, 1, 0, 0, 0, 1,  2, 3);
    tbl[3]  = mk(1,  3, 1, 0, 0, 0, 1,  3, 4);
    tbl[4]  = mk(1,  4, 1, 0, 0, 0, 1,  4, 5);
    tbl[5]  = mk(0,  0, 0, 1, 0, 0, 1,  4, 4);
    tbl[6]  = mk(0,  0, 0, 0, 1, 0, 1,  1, 4);
    tbl[7]  = mk(0,  0, 1, 0, 0, 0, 1,  2, 4);
    tbl[8]  = mk(0,  0, 1, 0, 0, 0, 1,  3, 4);
    tbl[9]  = mk(0,  0, 1, 0, 0, 0, 1,  4, 4);
    tbl[10] = mk(0,  0, 1, 0, 0, 0, 0,  0, 4);
    tbl[11] = mk(0,  0, 0, 0, 0, 1, 0,  0, 0);
    tbl[12] = mk(1, 20, 0, 0, 0, 0, 1, 20, 1);
    tbl[13] = mk(1, 21, 1, 0, 0, 0, 1, 21, 2);
    tbl[14] = mk(1, 22, 1, 0, 0, 0, 1, 22, 3);
    tbl[15] = mk(0,  0, 1, 0, 0, 0, 0,  0, 3);
    tbl[16] = mk(0,  0, 0, 1, 1, 0, 1, 21, 2);
    tbl[17] = mk(1, 23, 0, 0, 0, 0, 1, 21, 3);
    tbl[18] = mk(1, 24, 0, 0, 0, 0, 1, 21, 4);
    tbl[19] = mk(1, 25, 0, 0, 0, 1, 0,  0, 0);
    tbl[20] = mk(1, 26, 0, 0, 0, 0, 1, 26, 1);

    v4 = 0; yumi4 = 0; deq4 = 0; roll4 = 0; clr4 = 0; d4 = '0;
    idle8();
    reset_i = 0;
    step();
    step();
    chk("rst_v", W'(vo8), W'(0));
    chk("rst_count", W'(cnt8), W'(0));
    chk("rst_full", W'(full8), W'(0));
    chk("rst_ready", W'(rdy8), W'(0));
    reset_i = 1;
    step();
    chk("rel_ready", W'(rdy8), W'(1));
    chk("rel_v", W'(vo8), W'(0));

    // fill / drain through the scoreboard
    for (int i = 0; i < 8; i++) begin
      v8 = 1; d8 = W'(i);
      sb.push_back(W'(i));
      step();
    end
    chk("fill_full", W'(full8), W'(1));
    chk("fill_count", W'(cnt8), W'(8));
    chk("fill_ready", W'(rdy8), W'(0));
    d8 = W'(99);
    step();
    chk("hold_count", W'(cnt8), W'(8));
    v8 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_v", W'(vo8), W'(1));
      if (sb.size() > 0) chk("drain_data", do8, sb.pop_front());
      else chk("drain_sb", W'(0), W'(1));
      yumi8 = 1;
      step();
    end
    yumi8 = 0;
    chk("drain_vo", W'(vo8), W'(0));
    chk("drain_count", W'(cnt8), W'(8));
    deq8 = 1; v8 = 1; d8 = W'(77);
    step();
    v8 = 0;
    chk("deqfull_count", W'(cnt8), W'(7));
    chk("deqfull_ready", W'(rdy8), W'(1));
    chk("deqfull_v", W'(vo8), W'(0));
    for (int i = 0; i < 7; i++) step();
    deq8 = 0;
    chk("empty_count", W'(cnt8), W'(0));
    chk("empty_ready", W'(rdy8), W'(1));
    chk("empty_full", W'(full8), W'(0));

    // roll, roll+deq, clear with enqueue
    do_reset();
    foreach (tbl[i]) begin
      v8 = tbl[i].v[0]; d8 = W'(tbl[i].d);
      yumi8 = tbl[i].yumi[0]; deq8 = tbl[i].deq[0];
      roll8 = tbl[i].roll[0]; clr8 = tbl[i].clr[0];
      step();
      chk($sformatf("tbl%0d_v", i), W'(vo8), W'(tbl[i].ev));
      if (tbl[i].ev != 0)
        chk($sformatf("tbl%0d_data", i), do8, W'(tbl[i].ed));
      chk($sformatf("tbl%0d_count", i), W'(cnt8), W'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_ready", i), W'(rdy8), W'(1));
    end
    idle8();

    // reset mid-operation with roll asserted
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v8 = 1; d8 = W'(50 + i);
      step();
    end
    v8 = 0;
    yumi8 = 1;
    step();
    step();
    yumi8 = 0;
    chk("mid_count", W'(cnt8), W'(6));
    chk("mid_data", do8, W'(52));
    reset_i = 0; roll8 = 1;
    step();
    chk("midrst_v", W'(vo8), W'(0));
    chk("midrst_count", W'(cnt8), W'(0));
    chk("midrst_ready", W'(rdy8), W'(0));
    chk("midrst_full", W'(full8), W'(0));
    step();
    chk("midrst_ready2", W'(rdy8), W'(0));
    reset_i = 1; roll8 = 0;
    step();
    chk("midrel_ready", W'(rdy8), W'(1));
    chk("midrel_v", W'(vo8), W'(0));
    chk("midrel_count", W'(cnt8), W'(0));

    // wrap-around at full throughput on the 4-deep instance
    sb.delete();
    ew = 0; er = 0; ec = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      fe = (ew - ec) < 4;
      fy = (er < ew) && (cyc >= 3);
      fq = (ec < er) && (cyc >= 6);
      v4 = 1; d4 = W'(200 + ew);
      yumi4 = fy; deq4 = fq;
      if (fy) begin
        if (sb.size() > 0) chk("wrap_data", do4, sb.pop_front());
        else chk("wrap_sb", W'(0), W'(1));
      end
      if (fe) sb.push_back(W'(200 + ew));
      step();
      ew += int'(fe); er += int'(fy); ec += int'(fq);
      chk("wrap_count", W'(cnt4), W'(ew - ec));
      chk("wrap_full", W'(full4), W'((ew - ec) == 4));
    end
    v4 = 0; yumi4 = 0; deq4 = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
